// File: rtl/i2c_arbiter.sv
// Two-requester round-robin front end for a single-transfer I2C controller.
// Grants one request at a time, launches it, and returns the result or a timeout.
module i2c_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] rnw_i,
    input  logic [6:0] addr0_i,
    input  logic [6:0] addr1_i,
    input  logic [7:0] wdata0_i,
    input  logic [7:0] wdata1_i,
    output logic [1:0] gnt_o,
    output logic [1:0] rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic [1:0] rsp_err_o,
    output logic       start_o,
    output logic       read_enable_o,
    output logic [6:0] dev_addr_o,
    output logic [7:0] data_o,
    input  logic       done_i,
    input  logic       busy_i,
    input  logic       ack_error_i,
    input  logic [7:0] rdata_i
);

    localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitDone,
        StResp,
        StDrain
    } state_e;

    state_e      state_q, state_d;
    logic        lp_q;
    logic        win_q;
    logic        win_d;
    logic        timeout_q;
    logic [15:0] cnt_q;
    logic        grant;
    logic        cnt_hit;

    // Both asserting: the requester that did not win last time goes first.
    assign win_d   = (req_i == 2'b11) ? ~lp_q : req_i[1];
    assign cnt_hit = (cnt_q == CntLast);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        gnt_o       = 2'b00;
        start_o     = 1'b0;
        rsp_valid_o = 2'b00;
        unique case (state_q)
            StIdle: begin
                if (!busy_i && (req_i != 2'b00)) begin
                    grant   = 1'b1;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                start_o = 1'b1;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (done_i || cnt_hit) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                rsp_valid_o = win_q ? 2'b10 : 2'b01;
                state_d     = timeout_q ? StDrain : StIdle;
            end
            StDrain: begin
                if (!busy_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (grant) begin
            gnt_o = win_d ? 2'b10 : 2'b01;
        end
        // Pulses stay quiet for the whole reset cycle, whatever the old state was.
        if (!rst_ni) begin
            grant       = 1'b0;
            gnt_o       = 2'b00;
            start_o     = 1'b0;
            rsp_valid_o = 2'b00;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lp_q          <= 1'b1;
            win_q         <= 1'b0;
            timeout_q     <= 1'b0;
            cnt_q         <= 16'd0;
            read_enable_o <= 1'b0;
            dev_addr_o    <= 7'd0;
            data_o        <= 8'd0;
            rsp_rdata_o   <= 8'd0;
            rsp_err_o     <= 2'b00;
        end else begin
            if (grant) begin
                lp_q          <= win_d;
                win_q         <= win_d;
                read_enable_o <= rnw_i[win_d];
                dev_addr_o    <= win_d ? addr1_i : addr0_i;
                data_o        <= win_d ? wdata1_i : wdata0_i;
            end
            if (state_q == StLaunch) begin
                cnt_q     <= 16'd0;
                timeout_q <= 1'b0;
            end
            if (state_q == StWaitDone) begin
                cnt_q <= cnt_q + 16'd1;
                // A done on the final count wins over the timeout.
                if (done_i) begin
                    rsp_rdata_o <= read_enable_o ? rdata_i : 8'h00;
                    rsp_err_o   <= {1'b0, ack_error_i};
                end else if (cnt_hit) begin
                    timeout_q   <= 1'b1;
                    rsp_rdata_o <= 8'h00;
                    rsp_err_o   <= 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter: directed scenarios plus randomized transfers
// checked against a transfer-level reference model.
module tb_i2c_arbiter;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic [1:0] req_i;
    logic [1:0] rnw_i;
    logic [6:0] addr0_i;
    logic [6:0] addr1_i;
    logic [7:0] wdata0_i;
    logic [7:0] wdata1_i;
    logic [1:0] gnt_o;
    logic [1:0] rsp_valid_o;
    logic [7:0] rsp_rdata_o;
    logic [1:0] rsp_err_o;
    logic       start_o;
    logic       read_enable_o;
    logic [6:0] dev_addr_o;
    logic [7:0] data_o;
    logic       done_i;
    logic       busy_i;
    logic       ack_error_i;
    logic [7:0] rdata_i;

    int   total = 0;
    int   bad = 0;
    bit   lp_m;
    logic [7:0] last_rdata;
    logic [1:0] last_err;

    always #5 clk = ~clk;

    i2c_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .rnw_i        (rnw_i),
        .addr0_i      (addr0_i),
        .addr1_i      (addr1_i),
        .wdata0_i     (wdata0_i),
        .wdata1_i     (wdata1_i),
        .gnt_o        (gnt_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .start_o      (start_o),
        .read_enable_o(read_enable_o),
        .dev_addr_o   (dev_addr_o),
        .data_o       (data_o),
        .done_i       (done_i),
        .busy_i       (busy_i),
        .ack_error_i  (ack_error_i),
        .rdata_i      (rdata_i)
    );

    // Round-robin rule: sole requester wins; on contention the one not served last.
    function automatic bit pick(input logic [1:0] req, input bit lp);
        if (req == 2'b11) return !lp;
        return req[1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {1'b0, gnt_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, start_o, read_enable_o,
                  dev_addr_o, data_o}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transfer; delay = WAIT_DONE cycles before done_i, tmo = never answer.
    task automatic xfer(input logic [1:0] req, input logic [1:0] rnw, input logic [6:0] a0,
                        input logic [6:0] a1, input logic [7:0] w0, input logic [7:0] w1,
                        input int delay, input bit nack, input logic [7:0] rd, input bit tmo);
        bit         w;
        logic [6:0] ea;
        logic [7:0] ed;
        bit         er;
        w  = pick(req, lp_m);
        ea = w ? a1 : a0;
        ed = w ? w1 : w0;
        er = rnw[w];
        req_i = req; rnw_i = rnw; addr0_i = a0; addr1_i = a1;
        wdata0_i = w0; wdata1_i = w1; busy_i = 1'b0;
        #2;
        chk("gnt", gnt_o, 2'b01 << w);
        chk("start_in_idle", start_o, 0);
        step();
        lp_m = w;
        req_i[w] = 1'b0;
        #2;
        chk("start", start_o, 1);
        chk("gnt_clear", gnt_o, 0);
        chk("dev_addr", dev_addr_o, ea);
        chk("data", data_o, ed);
        chk("read_enable", read_enable_o, er);
        busy_i = 1'b1;
        step();
        if (!tmo) begin
            for (int i = 0; i < delay; i++) begin
                req_i = 2'($urandom);
                #2;
                chk("no_gnt_outside_idle", gnt_o, 0);
                chk("no_rsp_early", rsp_valid_o, 0);
                step();
            end
            req_i = 2'b00; done_i = 1'b1; ack_error_i = nack; rdata_i = rd;
            step();
            done_i = 1'b0; ack_error_i = 1'b0; busy_i = 1'b0; rdata_i = 8'($urandom);
            last_rdata = er ? rd : 8'h00;
            last_err   = {1'b0, nack};
        end else begin
            for (int i = 0; i < 16; i++) begin
                #2;
                chk("no_rsp_before_timeout", rsp_valid_o, 0);
                step();
            end
            last_rdata = 8'h00;
            last_err   = 2'b10;
        end
        #2;
        chk("rsp_valid", rsp_valid_o, 2'b01 << w);
        chk("rsp_rdata", rsp_rdata_o, last_rdata);
        chk("rsp_err", rsp_err_o, last_err);
        chk("dev_addr_hold", dev_addr_o, ea);
        step();
        #2;
        chk("rsp_valid_clear", rsp_valid_o, 0);
        chk("rdata_hold", rsp_rdata_o, last_rdata);
        chk("err_hold", rsp_err_o, last_err);
        if (tmo) begin
            req_i = 2'b11;
            for (int i = 0; i < 4; i++) begin
                #2;
                chk("no_gnt_drain", gnt_o, 0);
                step();
            end
            busy_i = 1'b0;
            #2;
            chk("no_gnt_drain_exit", gnt_o, 0);
            step();
            #2;
            chk("gnt_after_drain", gnt_o, 2'b01 << pick(2'b11, lp_m));
            req_i = 2'b00;
            #1;
        end
    endtask

    initial begin
        rst_ni = 1'b0; req_i = '0; rnw_i = '0; addr0_i = '0; addr1_i = '0;
        wdata0_i = '0; wdata1_i = '0; done_i = 1'b0; busy_i = 1'b0;
        ack_error_i = 1'b0; rdata_i = '0;
        step();
        step();
        #2;
        chk_zero("reset_outputs");
        rst_ni = 1'b1;
        lp_m = 1'b1;
        step();

        // Write, read, contention, nack, done on last count, immediate done
        xfer(2'b01, 2'b00, 7'h3C, 7'h00, 8'hA5, 8'h00, 3, 1'b0, 8'h00, 1'b0);
        xfer(2'b10, 2'b10, 7'h00, 7'h50, 8'h00, 8'h00, 5, 1'b0, 8'h7E, 1'b0);
        for (int k = 0; k < 4; k++) begin
            xfer(2'b11, 2'b01, 7'h11, 7'h22, 8'h33, 8'h44, k, 1'b0, 8'hC3, 1'b0);
        end
        xfer(2'b01, 2'b00, 7'h2A, 7'h00, 8'h5A, 8'h00, 2, 1'b1, 8'h00, 1'b0);
        xfer(2'b10, 2'b10, 7'h00, 7'h68, 8'h00, 8'h00, 15, 1'b0, 8'h9D, 1'b0);
        xfer(2'b11, 2'b11, 7'h01, 7'h02, 8'h03, 8'h04, 0, 1'b0, 8'hE1, 1'b0);

        // Controller never answers
        xfer(2'b01, 2'b00, 7'h45, 7'h00, 8'h67, 8'h00, 0, 1'b0, 8'h00, 1'b1);

        // Reset in the middle of WAIT_DONE, then a late done
        req_i = 2'b01; rnw_i = 2'b00; addr0_i = 7'h12; wdata0_i = 8'h34; busy_i = 1'b0;
        step();
        req_i = 2'b00; busy_i = 1'b1;
        step();
        step();
        rst_ni = 1'b0;
        step();
        #2;
        chk_zero("reset_mid_transfer");
        rst_ni = 1'b1;
        lp_m = 1'b1;
        done_i = 1'b1; ack_error_i = 1'b1; rdata_i = 8'hFF;
        #2;
        chk_zero("late_done");
        step();
        done_i = 1'b0; ack_error_i = 1'b0;
        #2;
        chk_zero("after_late_done");
        req_i = 2'b11;
        step();
        #2;
        chk("no_gnt_while_busy", gnt_o, 0);
        busy_i = 1'b0;
        #2;
        chk("gnt_after_busy_low", gnt_o, 2'b01 << pick(2'b11, lp_m));
        req_i = 2'b00;
        step();

        for (int n = 0; n < 30; n++) begin
            xfer(2'($urandom_range(1, 3)), 2'($urandom), 7'($urandom), 7'($urandom),
                 8'($urandom), 8'($urandom), int'($urandom_range(0, 15)),
                 1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
